// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Single-clock FIFO with occupancy count, almost-full/empty flags,
//            sticky overflow/underflow; first-word-fall-through output when
//            SYNC_FIFO_FWFT_EN is defined.
// Revision : 1.0
// ============================================================================
module sync_fifo_fwft #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    output logic                wfull,
    output logic                walmost_full,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic                ralmost_empty,
    input  logic [ADDRSIZE:0]   af_th,
    input  logic [ADDRSIZE:0]   ae_th,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                err_clr
);
    localparam int                c_DEPTH     = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] c_DEPTH_CNT = (ADDRSIZE+1)'(c_DEPTH);
    localparam logic [ADDRSIZE:0] c_ONE       = (ADDRSIZE+1)'(1);

    logic [DATASIZE-1:0] mem_q [c_DEPTH];
    logic [ADDRSIZE:0]   wptr_q, wptr_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic [ADDRSIZE:0]   count_q, count_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_arr_pop;

    assign wfull    = (count_q == c_DEPTH_CNT);
    assign w_wr_acc = winc && !wfull && rst_n;
    assign w_rd_acc = rinc && !rempty && rst_n;

`ifdef SYNC_FIFO_FWFT_EN
    logic valid_q, valid_d;

    // The output stage refills whenever it is empty or being consumed; the
    // pointers alone tell whether the array still holds a word.
    assign rempty    = !valid_q;
    assign w_arr_pop = (!valid_q || w_rd_acc) && (wptr_q != rptr_q) && rst_n;
    assign valid_d   = w_arr_pop ? 1'b1 : (w_rd_acc ? 1'b0 : valid_q);
`else
    assign rempty    = (count_q == '0);
    assign w_arr_pop = w_rd_acc;
`endif

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        overflow_d  = (winc && wfull) || (overflow_q && !err_clr);
        underflow_d = (rinc && rempty) || (underflow_q && !err_clr);
        if (w_wr_acc) begin
            wptr_d = wptr_q + c_ONE;
        end
        if (w_arr_pop) begin
            rptr_d  = rptr_q + c_ONE;
            rdata_d = mem_q[rptr_q[ADDRSIZE-1:0]];
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wptr_q[ADDRSIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
            valid_q     <= 1'b0;
`endif
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef SYNC_FIFO_FWFT_EN
            valid_q     <= valid_d;
`endif
        end
    end

    assign count         = count_q;
    assign rdata         = rdata_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign walmost_full  = (count_q >= af_th);
    assign ralmost_empty = (count_q <= ae_th);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_fwft
// Brief    : Directed plus random bench for sync_fifo_fwft against a queue model.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_fwft;
    logic       clk = 1'b0;
    logic       rst_n, winc, rinc, err_clr;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [4:0] af_th, ae_th, count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mq[$];
    logic       m_v, m_ovf, m_unf;
    logic [7:0] m_rdata;
    int         dut_peak;
    logic       any_full;

    sync_fifo_fwft #(.ADDRSIZE(4), .DATASIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
        .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .af_th(af_th), .ae_th(ae_th), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_v     = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".wfull"}, 32'(wfull), 32'(mq.size() == 16));
`ifdef SYNC_FIFO_FWFT_EN
        chk({tag, ".rempty"}, 32'(rempty), 32'(!m_v));
        if (m_v) chk({tag, ".rdata"}, 32'(rdata), 32'(mq[0]));
`else
        chk({tag, ".rempty"}, 32'(rempty), 32'(mq.size() == 0));
        chk({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
`endif
        chk({tag, ".afull"}, 32'(walmost_full), 32'(mq.size() >= int'(af_th)));
        chk({tag, ".aempty"}, 32'(ralmost_empty), 32'(mq.size() <= int'(ae_th)));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock: model predicts from pre-edge state, then DUT is compared after the edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic clr);
        int   sz;
        logic full, emp, wa, ra;
        winc = w; wdata = d; rinc = r; err_clr = clr;
        sz   = mq.size();
        full = (sz == 16);
`ifdef SYNC_FIFO_FWFT_EN
        emp  = !m_v;
`else
        emp  = (sz == 0);
`endif
        wa    = w && !full;
        ra    = r && !emp;
        m_ovf = (w && full) || (m_ovf && !clr);
        m_unf = (r && emp) || (m_unf && !clr);
`ifdef SYNC_FIFO_FWFT_EN
        if ((!m_v || ra) && (sz - int'(m_v)) > 0) m_v = 1'b1;
        else if (ra) m_v = 1'b0;
`endif
        if (ra) m_rdata = mq.pop_front();
        if (wa) mq.push_back(d);
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
        if (int'(count) > dut_peak) dut_peak = int'(count);
        if (wfull) any_full = 1'b1;
        check_all("cyc");
    endtask

    initial begin
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        af_th = 5'd12; ae_th = 5'd2;
        dut_peak = 0; any_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Asynchronous reset mid-stream at count 7
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h37, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_rdata", 32'(rdata), 32'h00);
        winc = 1'b1; wdata = 8'h55; rinc = 1'b1;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0;
        check_all("rst_hold");
        rst_n = 1'b1;

        // Fill and drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(wfull), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_head", 32'(rdata), 32'(i));
`endif
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_data", 32'(rdata), 32'(i));
`endif
        end
        chk("drain_empty", 32'(rempty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Pointer wrap
        dut_peak = 0; any_full = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) cycle(1'b1, 8'h40 + 8'(r * 10 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap_peak", 32'(dut_peak), 32'd10);
        chk("wrap_nofull", 32'(any_full), 32'd0);

        // Thresholds af_th=12, ae_th=2
        for (int i = 0; i < 11; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        chk("af_at11", 32'(walmost_full), 32'd0);
        cycle(1'b1, 8'h8B, 1'b0, 1'b0);
        chk("af_at12", 32'(walmost_full), 32'd1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ae_at3", 32'(ralmost_empty), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ae_at2", 32'(ralmost_empty), 32'd1);

        // Overflow / underflow
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write and read
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b0);
        chk("sim_full_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hDD, 1'b1, 1'b0);
        chk("sim_empty_count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_n_rempty", 32'(rempty), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft_n1_rempty", 32'(rempty), 32'd0);
        chk("fwft_n1_rdata", 32'(rdata), 32'hDD);
`else
        chk("std_rempty", 32'(rempty), 32'd0);
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("sim_mid_count", 32'(count), 32'd5);

        // Random traffic, write-biased then read-biased phases
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                af_th = 5'($urandom_range(0, 16));
                ae_th = 5'($urandom_range(0, 16));
            end
            if (i < 300)
                cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15) == 0);
            else
                cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
